// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C PWM LED target: FSM states, CTRL bit
// positions and the bus level that signals acknowledge.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_pwm_led_if.sv
// Open-drain I2C pin bundle: line sense inputs and pull-low drives.
interface i2c_pwm_led_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;

  modport slave  (input  scl_i, sda_i, output scl_o, sda_o);
  modport master (output scl_i, sda_i, input  scl_o, sda_o);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into clk and decodes START/STOP and SCL edges.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Idle bus is pulled high, so the pipeline resets to 1 to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign sda_o      = sda_sync_q;
  assign start_o    = scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
  assign stop_o     = scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;
  assign scl_rise_o =  scl_sync_q & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q &  scl_prev_q;

endmodule

// File: rtl/i2c_pwm_led.sv
// I2C target with a byte-addressed duty/CTRL register file driving NUM_CH
// PWM LED outputs; duty updates are deferred to the PWM period boundary.
module i2c_pwm_led
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'h4A,
  parameter int         NUM_CH  = 3,
  parameter int         PWM_W   = 8,
  parameter int         PWM_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_pwm_led_if.slave        bus,
  output logic [NUM_CH-1:0]   led_o
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic sda_s, start, stop, scl_rise, scl_fall;

  i2c_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .sda_o      (sda_s),
    .start_o    (start),
    .stop_o     (stop),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  i2c_state_e       state_q, state_d;
  logic [7:0]       shift_q, shift_d, ptr_q, ptr_d, rd_byte;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             sda_q, sda_d, rw_q, rw_d, mack_q, mack_d, wr_en;
  logic             byte_done, rx_bit;
  logic [PWM_W-1:0] shadow_q [NUM_CH];
  logic [PWM_W-1:0] duty_q   [NUM_CH];
  logic [1:0]       ctrl_q;

  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);
  assign rx_bit    = scl_rise && (bit_cnt_q != 4'd8);

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_CH; i++)
      if (ptr_q == 8'(i)) rd_byte = 8'(shadow_q[i]);
    if (ptr_q == 8'(NUM_CH)) rd_byte = {6'b0, ctrl_q};
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    sda_d     = sda_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    wr_en     = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
    end else if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WRITE: begin
          if (rx_bit) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = 4'd0;
            sda_d     = ACK;
            if (state_q == ST_ADDR) begin
              rw_d    = shift_q[0];
              state_d = ST_ADDR_ACK;
              if (shift_q[7:1] != ADDRESS) begin
                state_d = ST_WAIT_STOP;
                sda_d   = NACK;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = shift_q;
              state_d = ST_PTR_ACK;
            end else begin
              wr_en   = 1'b1;
              ptr_d   = ptr_q + 8'd1;
              state_d = ST_WRITE_ACK;
            end
          end
        end
        ST_ADDR_ACK, ST_READ_ACK: begin
          if (scl_rise) begin
            mack_d = (sda_s == ACK);
          end else if (scl_fall) begin
            if ((state_q == ST_ADDR_ACK && rw_q) || (state_q == ST_READ_ACK && mack_q)) begin
              shift_d = rd_byte;
              sda_d   = rd_byte[7];
              ptr_d   = ptr_q + 8'd1;
              state_d = ST_READ;
            end else begin
              sda_d   = 1'b1;
              state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WAIT_STOP;
            end
            bit_cnt_d = 4'd0;
          end
        end
        ST_PTR_ACK, ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = ST_WRITE;
          end
        end
        ST_READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ST_READ_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
            sda_d   = shift_q[6];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 8'h00;
      sda_q     <= 1'b1;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      sda_q     <= sda_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
    end
  end

  assign bus.sda_o = sda_q;
  assign bus.scl_o = 1'b1;

  // NOTE: the register file is a handful of flops that must read back 0 after reset, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      ctrl_q <= 2'b00;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ptr_q == 8'(i)) shadow_q[i] <= shift_q[PWM_W-1:0];
      if (ptr_q == 8'(NUM_CH)) ctrl_q <= shift_q[1:0];
    end
  end

  logic [PRE_W-1:0]  pre_q;
  logic [PWM_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] raw, led_q;
  logic              pre_wrap, cnt_wrap;

  assign pre_wrap = (pre_q == PRE_W'(PWM_DIV - 1));
  assign cnt_wrap = pre_wrap && (cnt_q == '1);

  // Active duty only changes together with the counter wrap, so no runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap) cnt_q <= cnt_q + PWM_W'(1);
      if (cnt_wrap)
        for (int i = 0; i < NUM_CH; i++) duty_q[i] <= shadow_q[i];
      led_q <= ctrl_q[CTRL_EN] ? (raw ^ {NUM_CH{ctrl_q[CTRL_INV]}}) : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pwm
    assign raw[g] = (duty_q[g] == '1) || (cnt_q < duty_q[g]);
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_i2c_pwm_led.sv
// Self-checking bench: I2C master BFM at clk/20 over a wired-AND bus, with a
// register-map reference model and PWM high-time measurement.
module tb_i2c_pwm_led;
  import i2c_pkg::*;

  localparam int NUM_CH = 3;
  localparam int PWM_W  = 8;
  localparam int Q      = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [NUM_CH-1:0] led;

  always #5 clk = ~clk;

  i2c_pwm_led_if bus ();
  assign bus.scl_i = scl_m & bus.scl_o;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_pwm_led #(
    .ADDRESS (7'h4A),
    .NUM_CH  (NUM_CH),
    .PWM_W   (PWM_W),
    .PWM_DIV (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led_o (led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: register map as a 256-entry byte array plus pointer.
  logic [7:0] mreg [256];
  logic [7:0] mptr;
  logic [7:0] tx_q [$];

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
    mptr = 8'h00;
  endfunction

  function automatic void m_write(input logic [7:0] d);
    if (mptr < NUM_CH) mreg[mptr] = d;
    else if (mptr == NUM_CH) mreg[mptr] = d & 8'h03;
    mptr = mptr + 8'd1;
  endfunction

  function automatic logic [7:0] m_read();
    logic [7:0] v;
    v = mreg[mptr];
    mptr = mptr + 8'd1;
    return v;
  endfunction

  function automatic int exp_high(input int ch);
    int h;
    h = (mreg[ch] == 8'hFF) ? 256 : int'(mreg[ch]);
    if (!mreg[NUM_CH][0]) return 0;
    return mreg[NUM_CH][1] ? 256 - h : h;
  endfunction

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait(); qwait();
  endtask

  task automatic put_bit(input logic v);
    sda_m = v; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic v);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    v = bus.sda_i; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic put_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    ack = ~a;
  endtask

  task automatic get_byte(output logic [7:0] b, input logic ack);
    logic v;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(v);
      b = {b[6:0], v};
    end
    put_bit(~ack);
  endtask

  // Sends abyte then every byte in tx_q; first data byte is the pointer.
  task automatic wr_txn(input logic [7:0] abyte, input logic do_stop);
    logic ack, match;
    match = (abyte[7:1] == 7'h4A) && !abyte[0];
    i2c_start();
    put_byte(abyte, ack);
    check("addr_ack", ack, match);
    for (int i = 0; i < tx_q.size(); i++) begin
      put_byte(tx_q[i], ack);
      check("data_ack", ack, match);
      if (match) begin
        if (i == 0) mptr = tx_q[i];
        else m_write(tx_q[i]);
      end
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    put_byte(8'h94, ack); check("rd_waddr_ack", ack, 1'b1);
    put_byte(ptr, ack);   check("rd_ptr_ack", ack, 1'b1);
    mptr = ptr;
    i2c_start();
    put_byte(8'h95, ack); check("rd_raddr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      get_byte(b, i != n - 1);
      check($sformatf("rd_data[%0d]", i), b, m_read());
    end
    check("rd_release", bus.sda_o, 1'b1);
    i2c_stop();
  endtask

  task automatic measure(input int ch, output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      hi += int'(led[ch]);
    end
  endtask

  task automatic pwm_all(input string tag);
    int hi;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      measure(ch, hi);
      check($sformatf("%s_led%0d", tag, ch), hi, exp_high(ch));
    end
  endtask

  initial begin
    int hi, run, bad, n64, n192;
    logic skip, late64, seen192, ack;
    logic [7:0] p;
    int len;

    m_reset();
    #23;
    check("rst_sda", bus.sda_o, 1'b1);
    check("rst_scl", bus.scl_o, 1'b1);
    check("rst_led", led, '0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Directed write, then read-back across the pointer with a repeated start.
    tx_q = '{8'h00, 8'h10, 8'h80, 8'hFF, 8'h01};
    wr_txn(8'h94, 1'b1);
    rd_txn(8'h01, 3);
    rd_txn(8'h00, 6);

    // Wrong address: NACK, no register change, parked until STOP.
    tx_q = '{8'h00, 8'h55};
    wr_txn(8'h96, 1'b0);
    check("nack_state", 32'(dut.state_q), 32'(ST_WAIT_STOP));
    i2c_stop();
    check("stop_idle", 32'(dut.state_q), 32'(ST_IDLE));
    rd_txn(8'h00, 4);

    // Pointer wrap: 0xFF discards, then wraps to register 0.
    tx_q = '{8'hFF, 8'h11, 8'h22};
    wr_txn(8'h94, 1'b1);
    rd_txn(8'h00, 1);

    // PWM duty, EN and INV.
    tx_q = '{8'h00, 8'h40, 8'h80, 8'hFF, 8'h01};
    wr_txn(8'h94, 1'b1);
    repeat (300) @(negedge clk);
    pwm_all("pwm_en");
    tx_q = '{8'h03, 8'h03};
    wr_txn(8'h94, 1'b1);
    repeat (4) @(negedge clk);
    pwm_all("pwm_inv");
    tx_q = '{8'h03, 8'h01};
    wr_txn(8'h94, 1'b1);
    repeat (300) @(negedge clk);

    // Mid-period duty change: every full pulse is 64 then 192, never a runt.
    bad = 0; n64 = 0; n192 = 0; late64 = 1'b0; seen192 = 1'b0;
    fork
      begin
        run = 0;
        skip = led[0];
        repeat (2500) begin
          @(negedge clk);
          if (led[0]) run++;
          else if (run > 0) begin
            if (!skip) begin
              if (run == 64) begin n64++; if (seen192) late64 = 1'b1; end
              else if (run == 192) begin n192++; seen192 = 1'b1; end
              else bad++;
            end
            skip = 1'b0;
            run = 0;
          end
        end
      end
      begin
        repeat (100) @(negedge clk);
        tx_q = '{8'h00, 8'hC0};
        wr_txn(8'h94, 1'b1);
      end
    join
    check("glitch_runts", bad, 0);
    check("glitch_saw64", n64 > 0, 1'b1);
    check("glitch_saw192", n192 > 0, 1'b1);
    check("glitch_order", late64, 1'b0);

    // Reset in the middle of a read data byte.
    tx_q = '{8'h00, 8'h3C};
    wr_txn(8'h94, 1'b1);
    i2c_start();
    put_byte(8'h94, ack); check("mid_waddr_ack", ack, 1'b1);
    put_byte(8'h00, ack); check("mid_ptr_ack", ack, 1'b1);
    i2c_start();
    put_byte(8'h95, ack); check("mid_raddr_ack", ack, 1'b1);
    check("mid_drive_low", bus.sda_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sda", bus.sda_o, 1'b1);
    check("mid_rst_led", led, '0);
    m_reset();
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tx_q = '{8'h02, 8'h33};
    wr_txn(8'h94, 1'b1);
    rd_txn(8'h00, 5);
    check("post_rst_led", led, '0);

    // Randomised writes over the map (including discarded pointers) and read-back.
    for (int t = 0; t < 6; t++) begin
      p   = 8'($urandom_range(0, 5));
      len = $urandom_range(1, 3);
      tx_q = '{p};
      for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
      wr_txn(8'h94, 1'b1);
    end
    tx_q = '{8'h03, 8'($urandom_range(0, 3) | 1)};
    wr_txn(8'h94, 1'b1);
    rd_txn(8'h00, 6);
    repeat (300) @(negedge clk);
    pwm_all("rand_pwm");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
